// File: rtl/pwd_serializer.sv
// Password word serializer: buffers code words in a FIFO and
// shifts each out MSB-first with an idle gap after every bit.
module pwd_serializer #(
  parameter int CODE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_GAP    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        code_valid,
  input  logic [CODE_W-1:0]           code_data,
  output logic                        code_ready,
  input  logic                        serial_ready,
  output logic                        serial_valid,
  output logic                        serial_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(CODE_W - 1);
  localparam logic [3:0] GAP_INIT =
    (BIT_GAP > 0) ? 4'(BIT_GAP - 1) : 4'd0;
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                more_q, more_d;
  logic                full;
  logic                push;
  logic                pop;

  assign full       = (count_q == DEPTH);
  assign code_ready = !full && !flush;
  assign push       = code_valid && code_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0) && !flush;

  assign fifo_count   = count_q;
  assign busy         = (count_q != '0) || (state_q != IDLE);
  assign serial_valid = (state_q == SEND);
  assign serial_data  = serial_valid && shreg_q[CODE_W-1];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // more_q remembers whether the bit just sent was not the last one,
  // since bit_cnt saturates at 0 and cannot tell us that by itself.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    more_d    = more_q;
    if (flush) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      more_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_d   = mem_q[rd_ptr_q];
            bit_cnt_d = LAST_BIT;
            state_d   = SEND;
          end
        end
        SEND: begin
          if (serial_ready) begin
            shreg_d = shreg_q << 1;
            more_d  = (bit_cnt_q != '0);
            if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - BW'(1);
            if (BIT_GAP > 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_INIT;
            end else if (bit_cnt_q == '0) begin
              state_d = IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_d = more_q ? SEND : IDLE;
          else gap_cnt_d = gap_cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= code_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      more_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      more_q    <= more_d;
    end
  end

endmodule

// File: tb/tb_pwd_serializer.sv
// Scoreboard bench for pwd_serializer: gap-1 and gap-0 instances,
// expected bit streams queued at word acceptance.
module tb_pwd_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_data = 4'd0;
  logic       serial_ready = 1'b1;
  logic       code_ready;
  logic       serial_valid;
  logic       serial_data;
  logic       busy;
  logic [2:0] fifo_count;

  logic       z_flush = 1'b0;
  logic       z_code_valid = 1'b0;
  logic [3:0] z_code_data = 4'd0;
  logic       z_serial_ready = 1'b1;
  logic       z_code_ready;
  logic       z_serial_valid;
  logic       z_serial_data;
  logic       z_busy;
  logic [2:0] z_fifo_count;

  int cmp = 0;
  int mis = 0;
  int n_bits = 0;
  int z_bits = 0;
  int base;
  bit exp_q[$];
  bit z_exp_q[$];

  always #5 clk = ~clk;

  pwd_serializer #(
    .CODE_W(4), .FIFO_DEPTH(4), .BIT_GAP(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .code_valid(code_valid), .code_data(code_data),
    .code_ready(code_ready), .serial_ready(serial_ready),
    .serial_valid(serial_valid), .serial_data(serial_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  pwd_serializer #(
    .CODE_W(4), .FIFO_DEPTH(4), .BIT_GAP(0)
  ) dut_z (
    .clk(clk), .reset(reset), .flush(z_flush),
    .code_valid(z_code_valid), .code_data(z_code_data),
    .code_ready(z_code_ready), .serial_ready(z_serial_ready),
    .serial_valid(z_serial_valid), .serial_data(z_serial_data),
    .busy(z_busy), .fifo_count(z_fifo_count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a bit is consumed whenever valid && ready before an edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("data_zero_when_idle", serial_valid || !serial_data, 1);
      if (serial_valid && serial_ready) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("bit", serial_data, exp_q.pop_front());
        n_bits++;
      end
      if (z_serial_valid && z_serial_ready) begin
        if (z_exp_q.size() == 0) chk("z_unexpected_bit", 1, 0);
        else chk("z_bit", z_serial_data, z_exp_q.pop_front());
        z_bits++;
      end
    end
  end

  task automatic push_word(input bit z, input logic [3:0] w);
    logic r;
    int t;
    r = 1'b0;
    t = 0;
    if (z) begin
      z_code_valid = 1'b1;
      z_code_data  = w;
    end else begin
      code_valid = 1'b1;
      code_data  = w;
    end
    while (!r && t < 100) begin
      @(negedge clk);
      r = z ? z_code_ready : code_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (z) z_code_valid = 1'b0;
    else code_valid = 1'b0;
    if (!r) chk("push_timeout", 0, 1);
    else
      for (int i = 3; i >= 0; i--)
        if (z) z_exp_q.push_back(w[i]);
        else exp_q.push_back(w[i]);
  endtask

  task automatic wait_bits(input int target);
    int t;
    t = 0;
    while (n_bits < target && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (n_bits < target) chk("wait_bits_timeout", n_bits, target);
  endtask

  task automatic wait_idle(input bit z);
    int t;
    t = 0;
    while ((z ? z_busy : busy) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_idle", z ? z_busy : busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_serial_valid", serial_valid, 0);
    chk("rst_serial_data", serial_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_code_ready", code_ready, 1);
    chk("rst_z_code_ready", z_code_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // single word cadence: bits after E0+1,3,5,7; idle after E0+9
    push_word(0, 4'b1011);
    for (int k = 0; k <= 9; k++) begin
      chk("t1_valid", serial_valid, (k % 2 == 1) && (k <= 7));
      chk("t1_busy", busy, k <= 8);
      @(posedge clk);
      #1;
    end

    // backpressure on bit 2
    push_word(0, 4'b1001);
    base = n_bits - 0;
    base = n_bits;
    wait_bits(base + 1);
    @(posedge clk);
    #1 serial_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_valid", serial_valid, 1);
      chk("t2_hold_data", serial_data, 0);
      @(posedge clk);
      #1;
    end
    serial_ready = 1'b1;
    chk("t2_hold_valid", serial_valid, 1);
    chk("t2_hold_data", serial_data, 0);
    wait_bits(base + 4);
    wait_idle(0);

    // fill: shreg + FIFO_DEPTH words, then blocked
    serial_ready = 1'b0;
    for (int w = 1; w <= 5; w++) push_word(0, 4'(w));
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_full", code_ready, 0);
    code_valid = 1'b1;
    code_data  = 4'd6;
    @(posedge clk);
    #1;
    chk("t3_still_blocked", code_ready, 0);
    chk("t3_count_held", fifo_count, 4);
    base = n_bits;
    serial_ready = 1'b1;
    push_word(0, 4'd6);
    chk("t3_w6_not_early", (n_bits - base) >= 4, 1);
    wait_bits(base + 24);
    wait_idle(0);

    // flush after two bits with two words queued
    base = n_bits;
    push_word(0, 4'b1011);
    push_word(0, 4'b0110);
    push_word(0, 4'b1100);
    wait_bits(base + 2);
    @(posedge clk);
    #1;
    chk("t4_queued", fifo_count, 2);
    flush      = 1'b1;
    code_valid = 1'b1;
    code_data  = 4'hF;
    #1;
    chk("t4_ready_in_flush", code_ready, 0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    code_valid = 1'b0;
    exp_q.delete();
    chk("t4_valid", serial_valid, 0);
    chk("t4_count", fifo_count, 0);
    chk("t4_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_busy_later", busy, 0);
    chk("t4_bits_sent", n_bits - base, 2);

    // async reset while presenting bit 2
    base = n_bits;
    push_word(0, 4'b1011);
    wait_bits(base + 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    serial_ready = 1'b0;
    chk("t5_pre_valid", serial_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", serial_valid, 0);
    chk("t5_data", serial_data, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_code_ready", code_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    serial_ready = 1'b1;
    base = n_bits;
    push_word(0, 4'b1011);
    @(posedge clk);
    #1;
    chk("t5_first_pop", serial_valid, 1);
    wait_bits(base + 4);
    wait_idle(0);

    // no-gap instance: back-to-back bits, one idle cycle per word
    push_word(1, 4'b1011);
    push_word(1, 4'b0101);
    for (int k = 1; k <= 10; k++) begin
      chk("t6_valid", z_serial_valid,
          (k >= 1 && k <= 4) || (k >= 6 && k <= 9));
      @(posedge clk);
      #1;
    end
    wait_idle(1);
    chk("t6_bits", z_bits, 8);

    chk("leftover_bits", exp_q.size(), 0);
    chk("z_leftover_bits", z_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mis);
    $finish;
  end

endmodule
